// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and digit helpers for the digit-serial BCD adder.
package bcd_pkg;

    localparam int unsigned DIGIT_W  = 4;
    localparam int unsigned BCD_MAX  = 9;
    localparam int unsigned BCD_CORR = 6;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAdd  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic logic nibble_valid(input logic [DIGIT_W-1:0] n);
        return n <= DIGIT_W'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder: s = (a+b+ci) mod 10, co = (a+b+ci) > 9.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               ci,
    output logic [DIGIT_W-1:0] s,
    output logic               co
);

    // 9 + 9 + 1 = 19 fits in one extra bit
    logic [DIGIT_W:0] t;

    always_comb begin
        t  = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, ci};
        co = (t > (DIGIT_W+1)'(BCD_MAX));
        // t - 10 equals (t + 6) mod 16 for t in 10..19
        s  = co ? DIGIT_W'(t + (DIGIT_W+1)'(BCD_CORR)) : t[DIGIT_W-1:0];
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder controller: one digit per cycle, LSD first,
// decimal carry rippled through a register.
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  invalid
);

    localparam int unsigned W     = DIGIT_W * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     sum_w;

    logic [DIGIT_W-1:0] dig_s;
    logic               dig_co;
    logic [W-1:0]       sum_nxt;
    logic               inputs_ok;

    // Operand registers shift right, so the current digit is always the low nibble
    bcd_digit_add u_digit (
        .a  (a_q[DIGIT_W-1:0]),
        .b  (b_q[DIGIT_W-1:0]),
        .ci (carry_q),
        .s  (dig_s),
        .co (dig_co)
    );

    always_comb begin
        sum_nxt = sum_w;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sum_nxt[DIGIT_W*k +: DIGIT_W] = dig_s;
            end
        end
    end

    always_comb begin
        inputs_ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (!nibble_valid(a[DIGIT_W*k +: DIGIT_W]) ||
                !nibble_valid(b[DIGIT_W*k +: DIGIT_W])) begin
                inputs_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_w   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            invalid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        sum_w   <= '0;
                        busy    <= 1'b1;
                        if (inputs_ok) begin
                            state_q <= StAdd;
                        end else begin
                            // Bad digits skip the add phase entirely
                            state_q <= StDone;
                            done    <= 1'b1;
                            sum     <= '0;
                            cout    <= 1'b0;
                            invalid <= 1'b1;
                        end
                    end
                end
                StAdd: begin
                    a_q     <= W'(a_q >> DIGIT_W);
                    b_q     <= W'(b_q >> DIGIT_W);
                    carry_q <= dig_co;
                    sum_w   <= sum_nxt;
                    if (idx_q == IDX_W'(DIGITS - 1)) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                        sum     <= sum_nxt;
                        cout    <= dig_co;
                        invalid <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench: integer-arithmetic reference model compared every cycle,
// plus directed literal cases for DIGITS=4 and DIGITS=1.
module tb_bcd_serial_add_ctrl;

    localparam int unsigned D   = 4;
    localparam int unsigned W   = 4 * D;
    localparam longint      LIM = 10000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout, invalid;
    logic [W-1:0] sum;

    logic         start1 = 1'b0;
    logic [3:0]   a1 = '0;
    logic [3:0]   b1 = '0;
    logic         cin1 = 1'b0;
    logic         busy1, done1, cout1, invalid1;
    logic [3:0]   sum1;

    int checks = 0;
    int failures = 0;

    bcd_serial_add_ctrl #(.DIGITS(D)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .invalid(invalid)
    );

    bcd_serial_add_ctrl #(.DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .invalid(invalid1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic longint bcd2int(input logic [W-1:0] x);
        longint v = 0;
        for (int k = D - 1; k >= 0; k--) v = v * 10 + longint'(x[4*k +: 4]);
        return v;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint v);
        logic [W-1:0] r = '0;
        longint       t = v;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit has_bad(input logic [W-1:0] x);
        for (int k = 0; k < D; k++) if (x[4*k +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: decimal arithmetic plus a countdown to the done cycle
    logic         m_busy, m_done, m_cout, m_inv, p_cout;
    logic [W-1:0] m_sum, p_sum;
    int           m_cnt;

    always @(posedge clk or posedge rst) begin
        longint total;
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_cout <= 1'b0; m_inv <= 1'b0;
            m_sum  <= '0;   p_sum  <= '0;   p_cout <= 1'b0; m_cnt <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_done <= 1'b1; m_sum <= p_sum; m_cout <= p_cout; m_inv <= 1'b0;
            end
        end else if (start) begin
            m_busy <= 1'b1;
            if (has_bad(a) || has_bad(b)) begin
                m_done <= 1'b1; m_sum <= '0; m_cout <= 1'b0; m_inv <= 1'b1;
            end else begin
                total  = bcd2int(a) + bcd2int(b) + longint'(cin);
                m_cnt  <= D;
                p_sum  <= int2bcd(total % LIM);
                p_cout <= (total >= LIM);
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("sum", 64'(sum), 64'(m_sum));
        chk("cout", 64'(cout), 64'(m_cout));
        chk("invalid", 64'(invalid), 64'(m_inv));
    end

    task automatic run_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic ci, input logic [W-1:0] es, input logic ec,
                          input logic ei, input int elat, input bit poke);
        int n = 1;
        int bc = 0;
        @(negedge clk);
        a = av; b = bv; cin = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        while (!done && n < 40) begin
            if (busy) bc++;
            if (poke) start = (n == 2);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (busy) bc++;
        chk({nm, " done_seen"}, 64'(done), 64'd1);
        chk({nm, " latency"}, 64'(n), 64'(elat));
        chk({nm, " busy_cycles"}, 64'(bc), 64'(elat));
        chk({nm, " sum"}, 64'(sum), 64'(es));
        chk({nm, " cout"}, 64'(cout), 64'(ec));
        chk({nm, " invalid"}, 64'(invalid), 64'(ei));
        if (poke) begin
            int extra = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (done) extra++;
            end
            chk({nm, " extra_done"}, 64'(extra), 64'd0);
        end
    endtask

    task automatic run1(input string nm, input logic [3:0] av, input logic [3:0] bv,
                        input logic ci, input logic [3:0] es, input logic ec,
                        input logic ei, input int elat);
        int n = 1;
        @(negedge clk);
        a1 = av; b1 = bv; cin1 = ci; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        while (!done1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " done_seen"}, 64'(done1), 64'd1);
        chk({nm, " latency"}, 64'(n), 64'(elat));
        chk({nm, " sum"}, 64'(sum1), 64'(es));
        chk({nm, " cout"}, 64'(cout1), 64'(ec));
        chk({nm, " invalid"}, 64'(invalid1), 64'(ei));
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset sum", 64'(sum), 64'd0);
        chk("reset cout", 64'(cout), 64'd0);
        chk("reset invalid", 64'(invalid), 64'd0);
        #2 rst = 1'b0;

        run_op("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 5, 1'b0);
        run_op("ripple_9999_1", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 5, 1'b0);
        run_op("max_9999_9999", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 5, 1'b0);
        run_op("bad_a_12A4", 16'h12A4, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1, 1'b0);
        run_op("bad_b_F000", 16'h0000, 16'hF000, 1'b0, 16'h0000, 1'b0, 1'b1, 1, 1'b0);
        run_op("ignored_start", 16'h0042, 16'h0058, 1'b0, 16'h0100, 1'b0, 1'b0, 5, 1'b1);

        // start held high: one result every DIGITS+2 cycles
        begin
            int last = -1;
            int nd = 0;
            @(negedge clk);
            a = 16'h0005; b = 16'h0005; cin = 1'b0; start = 1'b1;
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (done) begin
                    nd++;
                    chk("held sum", 64'(sum), 64'h0010);
                    if (last >= 0) chk("held period", 64'(i - last), 64'd6);
                    last = i;
                end
            end
            start = 1'b0;
            chk("held done_count", 64'(nd), 64'd6);
            repeat (3) @(negedge clk);
        end

        // reset during the second add cycle
        begin
            int nd = 0;
            @(negedge clk);
            a = 16'h4321; b = 16'h1111; cin = 1'b0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            #2 rst = 1'b1;
            #1;
            chk("abort busy", 64'(busy), 64'd0);
            chk("abort done", 64'(done), 64'd0);
            chk("abort sum", 64'(sum), 64'd0);
            chk("abort cout", 64'(cout), 64'd0);
            chk("abort invalid", 64'(invalid), 64'd0);
            @(negedge clk);
            #2 rst = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (done) nd++;
            end
            chk("abort no_done", 64'(nd), 64'd0);
            run_op("after_abort", 16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0, 1'b0, 5, 1'b0);
        end

        run1("d1_8_7_1", 4'h8, 4'h7, 1'b1, 4'h6, 1'b1, 1'b0, 2);
        run1("d1_9_9_1", 4'h9, 4'h9, 1'b1, 4'h9, 1'b1, 1'b0, 2);
        run1("d1_bad", 4'hA, 4'h1, 1'b0, 4'h0, 1'b0, 1'b1, 1);

        // randomized traffic, checked every cycle by the model
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            start = ($urandom_range(2) == 0);
            for (int k = 0; k < D; k++) begin
                a[4*k +: 4] = 4'($urandom_range(9));
                b[4*k +: 4] = 4'($urandom_range(9));
            end
            if ($urandom_range(7) == 0) a[4*$urandom_range(D-1) +: 4] = 4'($urandom_range(15, 10));
            if ($urandom_range(7) == 0) b[4*$urandom_range(D-1) +: 4] = 4'($urandom_range(15, 10));
            cin = 1'($urandom_range(1));
        end
        start = 1'b0;
        repeat (8) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
